// File: rtl/reg_file.sv
// Register bank for the simpleCPU datapath: one write port, two registered read ports
// with same-cycle write-to-read bypass and an optional hard-wired zero register.
module reg_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              We,
    input  logic [ADDR_W-1:0] Waddr,
    input  logic [WIDTH-1:0]  Wdata,
    input  logic              Re_a,
    input  logic [ADDR_W-1:0] Raddr_a,
    output logic [WIDTH-1:0]  Rdata_a,
    output logic              Rvalid_a,
    input  logic              Re_b,
    input  logic [ADDR_W-1:0] Raddr_b,
    output logic [WIDTH-1:0]  Rdata_b,
    output logic              Rvalid_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;

    // A write to register 0 is dropped entirely when it is the zero register.
    always_comb begin
        wr_ok = We && !((ZERO_REG != 0) && (Waddr == '0));
    end

    // Read value with bypass; the zero register overrides everything, bypass included.
    always_comb begin
        val_a = mem[Raddr_a];
        if (wr_ok && (Waddr == Raddr_a)) val_a = Wdata;
        if ((ZERO_REG != 0) && (Raddr_a == '0)) val_a = '0;
    end

    always_comb begin
        val_b = mem[Raddr_b];
        if (wr_ok && (Waddr == Raddr_b)) val_b = Wdata;
        if ((ZERO_REG != 0) && (Raddr_b == '0)) val_b = '0;
    end

    // NOTE: the storage array is reset too, because reset must clear every register
    // immediately; this rules out mapping it onto a RAM macro.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[Waddr] <= Wdata;
        end
    end

    // Rdata holds between requests; Rvalid is a one-cycle pulse per request.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Rdata_a  <= '0;
            Rvalid_a <= 1'b0;
            Rdata_b  <= '0;
            Rvalid_b <= 1'b0;
        end else begin
            Rvalid_a <= Re_a;
            Rvalid_b <= Re_b;
            if (Re_a) Rdata_a <= val_a;
            if (Re_b) Rdata_b <= val_b;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: two instances (ZERO_REG=0 and ZERO_REG=1) share
// stimulus; a reference model pushes expected read data to per-port scoreboard queues.
module tb_reg_file;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       We;
    logic [2:0] Waddr;
    logic [7:0] Wdata;
    logic       Re_a;
    logic [2:0] Raddr_a;
    logic       Re_b;
    logic [2:0] Raddr_b;

    logic [7:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic       rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: index 0 is the ZERO_REG=0 instance, index 1 the ZERO_REG=1 one.
    logic [7:0]  mm [2][8];
    logic [7:0]  hold_a [2];
    logic [7:0]  hold_b [2];
    logic [15:0] qa [$];
    logic [15:0] qb [$];

    always #5 Clk = ~Clk;

    reg_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .We(We), .Waddr(Waddr), .Wdata(Wdata),
        .Re_a(Re_a), .Raddr_a(Raddr_a), .Rdata_a(rdata_a0), .Rvalid_a(rvalid_a0),
        .Re_b(Re_b), .Raddr_b(Raddr_b), .Rdata_b(rdata_b0), .Rvalid_b(rvalid_b0)
    );

    reg_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .We(We), .Waddr(Waddr), .Wdata(Wdata),
        .Re_a(Re_a), .Raddr_a(Raddr_a), .Rdata_a(rdata_a1), .Rvalid_a(rvalid_a1),
        .Re_b(Re_b), .Raddr_b(Raddr_b), .Rdata_b(rdata_b1), .Rvalid_b(rvalid_b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_val(input int inst, input logic [2:0] addr,
                                             input logic we_i, input logic [2:0] wa,
                                             input logic [7:0] wd);
        logic zero_reg = (inst == 1);
        if (zero_reg && addr == 3'd0) return 8'h00;
        if (we_i && wa == addr && !(zero_reg && wa == 3'd0)) return wd;
        return mm[inst][addr];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 8; j++) mm[i][j] = 8'h00;
            hold_a[i] = 8'h00;
            hold_b[i] = 8'h00;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic set_idle();
        We = 1'b0; Waddr = 3'd0; Wdata = 8'h00;
        Re_a = 1'b0; Raddr_a = 3'd0; Re_b = 1'b0; Raddr_b = 3'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata_a0"}, rdata_a0, 0);  check({tag, "_rvalid_a0"}, rvalid_a0, 0);
        check({tag, "_rdata_b0"}, rdata_b0, 0);  check({tag, "_rvalid_b0"}, rvalid_b0, 0);
        check({tag, "_rdata_a1"}, rdata_a1, 0);  check({tag, "_rvalid_a1"}, rvalid_a1, 0);
        check({tag, "_rdata_b1"}, rdata_b1, 0);  check({tag, "_rvalid_b1"}, rvalid_b1, 0);
    endtask

    // Called between edges; whatever request is pending on the inputs is discarded.
    task automatic async_reset(input string tag);
        Rst_n = 1'b0;
        #1;
        check_all_zero({tag, "_imm"});
        clear_model();
        @(posedge Clk); #1;
        check_all_zero({tag, "_held"});
        set_idle();
        Rst_n = 1'b1;
    endtask

    // Drives one cycle of stimulus just after an edge, then checks just after the next.
    task automatic step(input logic we_i, input logic [2:0] wa, input logic [7:0] wd,
                        input logic rea, input logic [2:0] ra,
                        input logic reb, input logic [2:0] rb);
        logic [15:0] e;
        We = we_i; Waddr = wa; Wdata = wd;
        Re_a = rea; Raddr_a = ra; Re_b = reb; Raddr_b = rb;
        if (rea) qa.push_back({model_val(1, ra, we_i, wa, wd), model_val(0, ra, we_i, wa, wd)});
        if (reb) qb.push_back({model_val(1, rb, we_i, wa, wd), model_val(0, rb, we_i, wa, wd)});
        if (we_i) begin
            mm[0][wa] = wd;
            if (wa != 3'd0) mm[1][wa] = wd;
        end
        @(posedge Clk); #1;
        check("rvalid_a0", rvalid_a0, rea);
        check("rvalid_a1", rvalid_a1, rea);
        check("rvalid_b0", rvalid_b0, reb);
        check("rvalid_b1", rvalid_b1, reb);
        if (rea) begin
            check("sb_a_depth", qa.size(), 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                hold_a[0] = e[7:0];
                hold_a[1] = e[15:8];
            end
        end
        if (reb) begin
            check("sb_b_depth", qb.size(), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                hold_b[0] = e[7:0];
                hold_b[1] = e[15:8];
            end
        end
        check("rdata_a0", rdata_a0, hold_a[0]);
        check("rdata_a1", rdata_a1, hold_a[1]);
        check("rdata_b0", rdata_b0, hold_b[0]);
        check("rdata_b1", rdata_b1, hold_b[1]);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    initial begin
        set_idle();
        clear_model();
        Rst_n = 1'b0;
        #1;
        check_all_zero("por");
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("por_held");
        Rst_n = 1'b1;

        // Basic write then dual-port read, followed by an idle cycle that must hold data.
        step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 1'b0, 3'd0);
        step(1'b1, 3'd7, 8'hC3, 1'b0, 3'd0, 1'b0, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd7);
        idle();

        // Bypass on port A, then port B sees the committed value.
        step(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0);
        step(1'b1, 3'd2, 8'h99, 1'b1, 3'd2, 1'b0, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd2);
        idle();

        // Write to r0 with simultaneous reads of r0 on both ports.
        step(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 1'b1, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0);
        idle();

        // Streaming writes then eight back-to-back reads on port A.
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(i + 1), 1'b0, 3'd0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0, 3'd0);
        idle();

        // Mixed random traffic on both ports.
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        idle();

        // Asynchronous reset pulse between edges, then every register must read zero.
        #2;
        async_reset("mid_pulse");
        for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i));
        idle();

        // Reset arriving while a read request is pending before its edge.
        step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 1'b0, 3'd0);
        Re_a = 1'b1;
        Raddr_a = 3'd3;
        #2;
        async_reset("inflight");
        idle();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0);
        idle();

        check("sb_a_drained", qa.size(), 0);
        check("sb_b_drained", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
